if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 180 ++++++++++++++++++
 tb/tb_if_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a single-entry skid buffer
//
// The stage keeps at most one instruction-memory request in flight. The
// fetched word goes into the IF/ID register. If decode is stalled when the
// response arrives, the word is parked in a one-entry buffer instead.
// A redirect loads a new PC and squashes work that is in flight. A flush
// only bubbles the IF/ID register.
//
// Parameters
//   RESET_PC   fetch address loaded on reset
//   NOP_INSTR  bubble word written into IF/ID on reset/flush/redirect
//
// Optional feature (compile-time macro MISALIGN_CHECK_EN)
//   defined   : misalign_err pulses for one cycle after a redirect whose
//               target has non-zero low bits
//   undefined : misalign_err is tied low
//   In both builds the low two bits of redirect_pc are ignored.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall, flush        decode stall (hold IF/ID + PC), IF/ID bubble
//   redirect, redirect_pc  taken branch/jump and its target
//   imem_req/addr/ready    request handshake (addr always equals pc)
//   imem_rvalid/rdata      response
//   if_valid, if_pc, if_pc_plus4, if_instr   IF/ID register
//   opcode, funct3, funct7  decode fields taken straight from if_instr
//   misalign_err        misaligned-redirect flag
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, WAIT, BUF, KILL} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] buf_instr_reg;
    logic [31:0] buf_pc_reg;
    logic        if_valid_reg;
    logic [31:0] if_pc_reg;
    logic [31:0] if_instr_reg;
    // Set when reset hits while a response is still owed by memory. The
    // stage sits in IDLE but must swallow that stale response before it
    // issues a new request.
    logic        drop_pending_reg;

    logic [31:0] redirect_target;
    logic        accept;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign imem_req  = (state_reg == IDLE) && !drop_pending_reg && !redirect && !rst;
    assign imem_addr = pc_reg;
    assign accept    = imem_req && imem_ready;

    assign if_valid    = if_valid_reg;
    assign if_pc       = if_pc_reg;
    assign if_pc_plus4 = if_pc_reg + 32'd4;
    assign if_instr    = if_instr_reg;
    assign opcode      = if_instr_reg[6:0];
    assign funct3      = if_instr_reg[14:12];
    assign funct7      = if_instr_reg[31:25];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            state_reg     <= IDLE;
            buf_instr_reg <= 32'd0;
            buf_pc_reg    <= 32'd0;
            if_valid_reg  <= 1'b0;
            if_pc_reg     <= RESET_PC;
            if_instr_reg  <= NOP_INSTR;
            // A response arriving in this very cycle is consumed by the reset.
            drop_pending_reg <= ((state_reg == WAIT) || (state_reg == KILL) || drop_pending_reg)
                                && !imem_rvalid;
        end else begin
            // IF/ID register. A bubble has priority over any load, including
            // a load that would otherwise happen under stall=0.
            if (flush || redirect) begin
                if_valid_reg <= 1'b0;
                if_instr_reg <= NOP_INSTR;
            end else if (state_reg == WAIT && imem_rvalid && !stall) begin
                if_valid_reg <= 1'b1;
                if_instr_reg <= imem_rdata;
                if_pc_reg    <= pc_reg;
            end else if (state_reg == BUF && !stall) begin
                if_valid_reg <= 1'b1;
                if_instr_reg <= buf_instr_reg;
                if_pc_reg    <= buf_pc_reg;
            end

            if (drop_pending_reg && imem_rvalid) begin
                drop_pending_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (redirect) begin
                        pc_reg <= redirect_target;
                    end else if (accept) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc_reg    <= redirect_target;
                        state_reg <= imem_rvalid ? IDLE : KILL;
                    end else if (imem_rvalid) begin
                        pc_reg <= pc_reg + 32'd4;
                        if (stall) begin
                            buf_instr_reg <= imem_rdata;
                            buf_pc_reg    <= pc_reg;
                            state_reg     <= BUF;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                BUF: begin
                    if (redirect) begin
                        pc_reg    <= redirect_target;
                        state_reg <= IDLE;
                    end else if (!stall) begin
                        state_reg <= IDLE;
                    end
                end
                KILL: begin
                    if (redirect) begin
                        pc_reg <= redirect_target;
                    end
                    if (imem_rvalid) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MISALIGN_CHECK_EN
    logic misalign_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err_reg <= 1'b0;
        end else begin
            misalign_err_reg <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign_err = misalign_err_reg;
`else
    // Low target bits are deliberately discarded in this build.
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign misalign_err    = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef MISALIGN_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0, stall = 1'b0, flush = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic        if_valid, misalign_err;
    logic [31:0] if_pc, if_pc_plus4, if_instr;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .misalign_err(misalign_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: tracks "a response is owed" / "that response is stale"
    // and an optional parked word, rather than explicit FSM states.
    logic        m_pending = 1'b0, m_stale = 1'b0, m_buffered = 1'b0;
    logic [31:0] m_buf_instr = 32'd0, m_buf_pc = 32'd0;
    logic [31:0] m_pc = RPC;
    logic        m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_if_pc = RPC, m_instr = NOP;
    logic        m_req = 1'b0;
    logic [31:0] m_addr = 32'd0;

    // Memory responder
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = 32'd0;
    int          lat_min = 0, lat_max = 0;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_word = 32'd0;

    logic        obs_req;
    logic [31:0] obs_addr;

    logic [114:0] dut_vec;
    assign dut_vec = {if_valid, if_pc, if_pc_plus4, if_instr, opcode, funct3, funct7, misalign_err};

    function automatic logic [114:0] exp_vec();
        return {m_valid, m_if_pc, m_if_pc + 32'd4, m_instr, m_instr[6:0], m_instr[14:12],
                m_instr[31:25], m_err};
    endfunction

    // One clock cycle: drive inputs at the falling edge, sample the request
    // side, then advance the model and memory across the rising edge.
    task automatic step(input logic i_rst, input logic i_stall, input logic i_flush,
                        input logic i_redir, input logic [31:0] i_rpc, input logic i_ready);
        logic        dlv;
        logic [31:0] dlv_i, dlv_p;
        logic        rv;
        logic [31:0] rd;
        @(negedge clk);
        rst = i_rst; stall = i_stall; flush = i_flush; redirect = i_redir;
        redirect_pc = i_rpc; imem_ready = i_ready;
        rv = mem_busy && (mem_cnt == 0);
        rd = rv ? mem_data : $urandom;
        imem_rvalid = rv; imem_rdata = rd;
        m_req  = !i_rst && !m_pending && !m_buffered && !i_redir;
        m_addr = m_pc;
        #1;
        obs_req = imem_req; obs_addr = imem_addr;
        @(posedge clk);
        dlv = 1'b0; dlv_i = 32'd0; dlv_p = 32'd0;
        if (i_rst) begin
            m_pending = m_pending && !rv;
            m_stale = 1'b1; m_buffered = 1'b0; m_pc = RPC;
            m_valid = 1'b0; m_instr = NOP; m_if_pc = RPC; m_err = 1'b0;
        end else begin
            if (rv && m_pending) begin
                if (!m_stale && !i_redir) begin
                    if (i_stall) begin
                        m_buffered = 1'b1; m_buf_instr = rd; m_buf_pc = m_pc;
                    end else begin
                        dlv = 1'b1; dlv_i = rd; dlv_p = m_pc;
                    end
                    m_pc = m_pc + 32'd4;
                end
                m_pending = 1'b0;
            end else if (m_buffered && !i_stall) begin
                dlv = 1'b1; dlv_i = m_buf_instr; dlv_p = m_buf_pc; m_buffered = 1'b0;
            end
            if (i_redir) begin
                m_buffered = 1'b0;
                m_pc = {i_rpc[31:2], 2'b00};
                if (m_pending) m_stale = 1'b1;
            end
            if (m_req && i_ready) begin
                m_pending = 1'b1; m_stale = 1'b0;
            end
            if (i_flush || i_redir) begin
                m_valid = 1'b0; m_instr = NOP;
            end else if (dlv) begin
                m_valid = 1'b1; m_instr = dlv_i; m_if_pc = dlv_p;
            end
            m_err = EXP_ERR && i_redir && (i_rpc[1:0] != 2'b00);
        end
        if (rv) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (m_req && i_ready) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(lat_max, lat_min);
            mem_data = fixed_en ? fixed_word : $urandom;
        end
    endtask

    task automatic idle_step(input logic i_ready);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, i_ready);
    endtask

    // Let any in-flight response drain without starting a new one.
    task automatic settle();
        int k;
        k = 0;
        while ((m_pending || m_buffered) && k < 20) begin
            idle_step(1'b0);
            k++;
        end
        n_cmp++;
        if (m_pending || m_buffered) begin
            n_bad++;
            $display("FAIL settle_timeout: pending=%0b buffered=%0b after %0d cycles, need idle",
                     m_pending, m_buffered, k);
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        n_cmp++;
        if (obs_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_req: got %0b want 0", obs_req);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        #1;
        n_cmp++;
        if ({if_valid, if_instr, if_pc, if_pc_plus4, opcode, misalign_err} !==
            {1'b0, NOP, RPC, RPC + 32'd4, 7'h13, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got v=%0b i=%h pc=%h p4=%h op=%h err=%0b want v=0 i=%h pc=%h",
                     if_valid, if_instr, if_pc, if_pc_plus4, opcode, misalign_err, NOP, RPC);
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pcs[$];
        int first_valid;
        fixed_en = 1'b1; fixed_word = 32'h0050_0093; lat_min = 0; lat_max = 0;
        first_valid = -1;
        for (int c = 1; c <= 10; c++) begin
            idle_step(1'b1);
            #1;
            if (if_valid && first_valid < 0) first_valid = c;
            if (if_valid && (pcs.size() == 0 || pcs[$] !== if_pc)) pcs.push_back(if_pc);
        end
        n_cmp++;
        if (first_valid != 2) begin
            n_bad++; $display("FAIL seq_latency: first if_valid at cycle %0d want 2", first_valid);
        end
        n_cmp++;
        if (pcs.size() < 3 || pcs[0] !== 32'h0 || pcs[1] !== 32'h4 || pcs[2] !== 32'h8) begin
            n_bad++;
            $display("FAIL seq_pcs: got %0d entries first=%h want 00000000,00000004,00000008",
                     pcs.size(), (pcs.size() > 0) ? pcs[0] : 32'hx);
        end
        n_cmp++;
        if ({if_valid, opcode, if_instr} !== {1'b1, 7'h13, 32'h0050_0093}) begin
            n_bad++;
            $display("FAIL seq_decode: got v=%0b op=%h i=%h want v=1 op=13 i=00500093",
                     if_valid, opcode, if_instr);
        end
    endtask

    task automatic test_stall();
        logic [64:0] snap;
        settle();
        fixed_en = 1'b1; fixed_word = 32'h0000_0033; lat_min = 0; lat_max = 0;
        snap = {m_valid, m_if_pc, m_instr};
        idle_step(1'b1);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
            #1;
            n_cmp++;
            if ({if_valid, if_pc, if_instr} !== snap) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got %h want %h", s, {if_valid, if_pc, if_instr}, snap);
            end
        end
        idle_step(1'b0);
        #1;
        n_cmp++;
        if ({if_valid, if_instr} !== {1'b1, 32'h0000_0033}) begin
            n_bad++;
            $display("FAIL stall_release: got v=%0b i=%h want v=1 i=00000033", if_valid, if_instr);
        end
    endtask

    task automatic test_redirect();
        settle();
        fixed_en = 1'b0; lat_min = 1; lat_max = 1;
        idle_step(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
        #1;
        n_cmp++;
        if ({obs_req, if_valid, if_instr} !== {1'b0, 1'b0, NOP}) begin
            n_bad++;
            $display("FAIL redir_bubble: got req=%0b v=%0b i=%h want req=0 v=0 i=%h",
                     obs_req, if_valid, if_instr, NOP);
        end
        idle_step(1'b1);
        #1;
        n_cmp++;
        if ({obs_req, if_valid, if_instr} !== {1'b0, 1'b0, NOP}) begin
            n_bad++;
            $display("FAIL redir_drop: got req=%0b v=%0b i=%h want req=0 v=0 i=%h",
                     obs_req, if_valid, if_instr, NOP);
        end
        idle_step(1'b1);
        n_cmp++;
        if ({obs_req, obs_addr} !== {1'b1, 32'h0000_0100}) begin
            n_bad++;
            $display("FAIL redir_addr: got req=%0b addr=%h want req=1 addr=00000100", obs_req, obs_addr);
        end
    endtask

    task automatic test_flush_stall();
        logic [31:0] snap_pc;
        settle();
        lat_min = 0; lat_max = 0;
        idle_step(1'b1);
        idle_step(1'b0);
        snap_pc = m_pc;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        #1;
        n_cmp++;
        if ({if_valid, if_instr} !== {1'b0, NOP}) begin
            n_bad++;
            $display("FAIL flush_stall: got v=%0b i=%h want v=0 i=%h", if_valid, if_instr, NOP);
        end
        idle_step(1'b0);
        n_cmp++;
        if ({obs_req, obs_addr} !== {1'b1, snap_pc}) begin
            n_bad++;
            $display("FAIL flush_pc: got req=%0b addr=%h want req=1 addr=%h", obs_req, obs_addr, snap_pc);
        end
    endtask

    task automatic test_wrap();
        settle();
        lat_min = 0; lat_max = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle_step(1'b1);
        n_cmp++;
        if ({obs_req, obs_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_bad++; $display("FAIL wrap_req: got req=%0b addr=%h want req=1 addr=fffffffc", obs_req, obs_addr);
        end
        idle_step(1'b0);
        #1;
        n_cmp++;
        if ({if_valid, if_pc, if_pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            n_bad++;
            $display("FAIL wrap_plus4: got v=%0b pc=%h p4=%h want v=1 pc=fffffffc p4=00000000",
                     if_valid, if_pc, if_pc_plus4);
        end
        idle_step(1'b0);
        n_cmp++;
        if (obs_addr !== 32'h0) begin
            n_bad++; $display("FAIL wrap_next: got addr=%h want 00000000", obs_addr);
        end
    endtask

    task automatic test_misalign();
        settle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
        #1;
        n_cmp++;
        if (misalign_err !== EXP_ERR) begin
            n_bad++; $display("FAIL misalign_pulse: got %0b want %0b", misalign_err, EXP_ERR);
        end
        idle_step(1'b0);
        #1;
        n_cmp++;
        if ({misalign_err, obs_addr} !== {1'b0, 32'h0000_0100}) begin
            n_bad++;
            $display("FAIL misalign_after: got err=%0b addr=%h want err=0 addr=00000100", misalign_err, obs_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        settle();
        lat_min = 2; lat_max = 2;
        idle_step(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) idle_step(1'b1);
            #1;
            n_cmp++;
            if ({obs_req, obs_addr, dut_vec} !== {m_req, m_addr, exp_vec()}) begin
                n_bad++;
                $display("FAIL rst_wait[%0d]: got req=%0b addr=%h out=%h want req=%0b addr=%h out=%h",
                         c, obs_req, obs_addr, dut_vec, m_req, m_addr, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        fixed_en = 1'b0; lat_min = 0; lat_max = 3;
        for (int c = 0; c < 3000; c++) begin
            rpc = $urandom;
            step(($urandom_range(199, 0) == 0), ($urandom_range(3, 0) == 0),
                 ($urandom_range(15, 0) == 0), ($urandom_range(11, 0) == 0),
                 rpc, ($urandom_range(9, 0) < 7));
            #1;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL rand_ifid[%0d]: got %h want %h", c, dut_vec, exp_vec());
            end
            n_cmp++;
            if ({obs_req, obs_addr} !== {m_req, m_addr}) begin
                n_bad++;
                $display("FAIL rand_req[%0d]: got req=%0b addr=%h want req=%0b addr=%h",
                         c, obs_req, obs_addr, m_req, m_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush_stall();
        test_wrap();
        test_misalign();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
